// File: rtl/mul_div_seq.sv
// Iterative 32-bit multiply/divide sequencer that time-shares an external add/sub unit.
// Signed ops are computed on magnitudes, with the signs restored in two fix-up cycles.
module mul_div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             busy,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_sub,
  input  logic [WIDTH-1:0] add_result,
  input  logic             add_cf
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_NEG_A, S_NEG_B, S_ITER, S_FIX_LO, S_FIX_HI, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               is_div_q, is_div_d;
  logic               a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic               res_valid_q, res_valid_d, busy_q, busy_d, cmd_ready_q, cmd_ready_d;
  logic [WIDTH-1:0]   b_abs, sh;
  logic               qbit, neg_hi;

  // Next-state, datapath and adder-operand decode
  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    add_a    = '0;
    add_b    = '0;
    add_sub  = 1'b0;
    b_abs    = b_q;
    sh       = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    qbit     = 1'b0;
    neg_hi   = is_div_q ? a_neg_q : (a_neg_q ^ b_neg_q);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          is_div_d = cmd_op[1];
          a_neg_d  = cmd_op[0] & cmd_a[WIDTH-1];
          b_neg_d  = cmd_op[0] & cmd_b[WIDTH-1];
          a_d      = cmd_a;
          b_d      = cmd_b;
          cnt_d    = '0;
          // Divide by zero short-circuits straight to the result
          if (cmd_op[1] && (cmd_b == '0)) begin
            hi_d    = cmd_a;
            lo_d    = '1;
            state_d = S_DONE;
          end else begin
            state_d = S_NEG_A;
          end
        end
      end
      S_NEG_A: begin
        if (a_neg_q) begin
          add_sub = 1'b1;
          add_b   = a_q;
          a_d     = add_result;
        end
        state_d = S_NEG_B;
      end
      S_NEG_B: begin
        if (b_neg_q) begin
          add_sub = 1'b1;
          add_b   = b_q;
          b_abs   = add_result;
        end
        b_d     = b_abs;
        hi_d    = '0;
        lo_d    = is_div_q ? a_q : b_abs;
        cnt_d   = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        if (!is_div_q) begin
          add_a = hi_q;
          add_b = lo_q[0] ? a_q : '0;
          hi_d  = {add_cf, add_result[WIDTH-1:1]};
          lo_d  = {add_result[0], lo_q[WIDTH-1:1]};
        end else begin
          // Restoring division; the 33rd bit (hi_q msb) forces a subtract
          add_a   = sh;
          add_b   = b_q;
          add_sub = 1'b1;
          qbit    = hi_q[WIDTH-1] | ~add_cf;
          hi_d    = qbit ? add_result : sh;
          lo_d    = {lo_q[WIDTH-2:0], qbit};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX_LO;
        end
      end
      S_FIX_LO: begin
        if (a_neg_q ^ b_neg_q) begin
          add_sub = 1'b1;
          add_b   = lo_q;
          lo_d    = add_result;
        end
        state_d = S_FIX_HI;
      end
      S_FIX_HI: begin
        // 64-bit negate: borrow into hi only when the low word was zero
        if (neg_hi) begin
          if (is_div_q || (lo_q == '0)) begin
            add_sub = 1'b1;
            add_b   = hi_q;
            hi_d    = add_result;
          end else begin
            hi_d = ~hi_q;
          end
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    res_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    cmd_ready_d = (state_d == S_IDLE);
    res_hi_d    = res_hi_q;
    res_lo_d    = res_lo_q;
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      res_hi_d = hi_d;
      res_lo_d = lo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      is_div_q    <= 1'b0;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
      res_hi_q    <= '0;
      res_lo_q    <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      is_div_q    <= is_div_d;
      a_neg_q     <= a_neg_d;
      b_neg_q     <= b_neg_d;
      a_q         <= a_d;
      b_q         <= b_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
      res_hi_q    <= res_hi_d;
      res_lo_q    <= res_lo_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_hi    = res_hi_q;
  assign res_lo    = res_lo_q;
  assign busy      = busy_q;
  assign cmd_ready = cmd_ready_q;

endmodule
